// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor with valid/ready flow control
//
// Purpose:
//   Computes a + b + cin (add) or a + ~b + 1 (subtract) modulo 2^WIDTH,
//   together with the carry out of the MSB and the two's-complement overflow.
//   The WIDTH/GROUP lookahead groups are split evenly over STAGES pipeline
//   stages. Within a group, bit carries come from generate/propagate
//   lookahead. Within a stage, group carries come from group-level lookahead.
//   The carry between stages, the partial sum and the operand bits not yet
//   processed travel down the pipe together.
//
// Parameters:
//   WIDTH  - operand/result width; must be a multiple of GROUP
//   GROUP  - lookahead group size in bits
//   STAGES - pipeline depth, 1..WIDTH/GROUP; must divide WIDTH/GROUP
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   in_valid  in   operand set present on a, b, cin, sub
//   in_ready  out  operands accepted this cycle (pipeline advancing)
//   a, b      in   WIDTH-bit operands
//   cin       in   carry-in, ignored when sub=1
//   sub       in   0 = add, 1 = subtract
//   out_valid out  sum/cout/ovf hold a result
//   out_ready in   downstream takes the result this cycle
//   sum       out  WIDTH-bit result, 0 while out_valid=0
//   cout      out  carry out of bit WIDTH-1 (1 = no borrow when subtracting)
//   ovf       out  signed overflow
`timescale 1ns/1ps

module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NGROUPS = WIDTH / GROUP;
    localparam int GPS     = NGROUPS / STAGES;
    localparam int LAST    = STAGES - 1;

    // Lookahead carries for an n-bit generate/propagate vector:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c0, each carry formed
    // directly from g/p rather than rippled. Bits at and above n are unused.
    function automatic logic [WIDTH:0] lookahead(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input logic             c0,
        input int               n
    );
        logic [WIDTH:0] c;
        logic           t;
        logic           pp;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < n) begin
                t  = 1'b0;
                pp = 1'b1;
                for (int j = WIDTH - 1; j >= 0; j--) begin
                    if (j <= i) begin
                        t  = t | (g[j] & pp);
                        pp = pp & p[j];
                    end
                end
                c[i+1] = t | (pp & c0);
            end
        end
        return c;
    endfunction

    // Stage registers. b_q holds the already-conditioned operand (~b when
    // subtracting), so later stages never need to know the mode. c_q is the
    // carry out of the highest group processed so far.
    logic             v_q   [STAGES];
    logic             v_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];
    logic             ovf_q [STAGES];
    logic             ovf_d [STAGES];

    logic advance;

    assign out_valid = v_q[LAST];
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;

    always_comb begin
        logic             vi;
        logic             ci;
        logic             cm;
        logic [WIDTH-1:0] ai;
        logic [WIDTH-1:0] bi;
        logic [WIDTH-1:0] si;
        logic [WIDTH-1:0] so;
        logic [WIDTH-1:0] bit_g;
        logic [WIDTH-1:0] bit_p;
        logic [WIDTH-1:0] grp_g;
        logic [WIDTH-1:0] grp_p;
        logic [WIDTH:0]   lc;
        logic [WIDTH:0]   gc;
        int               lo;
        int               kp;

        vi    = 1'b0;
        ci    = 1'b0;
        cm    = 1'b0;
        ai    = '0;
        bi    = '0;
        si    = '0;
        so    = '0;
        bit_g = '0;
        bit_p = '0;
        grp_g = '0;
        grp_p = '0;
        lc    = '0;
        gc    = '0;
        lo    = 0;
        kp    = 0;

        for (int k = 0; k < STAGES; k++) begin
            kp = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                // Subtract folds into add: a + ~b + 1, with the +1 as carry-in.
                vi = in_valid;
                ai = a;
                bi = sub ? ~b : b;
                ci = sub | cin;
                si = '0;
            end else begin
                vi = v_q[kp];
                ai = a_q[kp];
                bi = b_q[kp];
                ci = c_q[kp];
                si = s_q[kp];
            end

            bit_g = ai & bi;
            bit_p = ai ^ bi;
            grp_g = '0;
            grp_p = '0;

            // Group generate/propagate for the groups owned by this stage.
            for (int gi = 0; gi < GPS; gi++) begin
                lo        = (k * GPS + gi) * GROUP;
                lc        = lookahead(WIDTH'(bit_g[lo +: GROUP]),
                                      WIDTH'(bit_p[lo +: GROUP]), 1'b0, GROUP);
                grp_g[gi] = lc[GROUP];
                grp_p[gi] = &bit_p[lo +: GROUP];
            end

            // Carries into each group of this stage, from the stage carry-in.
            gc = lookahead(grp_g, grp_p, ci, GPS);

            // Bit carries and sum bits; the carry into the stage's top bit is
            // kept so the final stage can form the signed overflow.
            so = si;
            cm = 1'b0;
            for (int gi = 0; gi < GPS; gi++) begin
                lo               = (k * GPS + gi) * GROUP;
                lc               = lookahead(WIDTH'(bit_g[lo +: GROUP]),
                                             WIDTH'(bit_p[lo +: GROUP]), gc[gi], GROUP);
                so[lo +: GROUP]  = bit_p[lo +: GROUP] ^ lc[GROUP-1:0];
                cm               = lc[GROUP-1];
            end

            v_d[k]   = vi;
            s_d[k]   = so;
            a_d[k]   = ai;
            b_d[k]   = bi;
            c_d[k]   = gc[GPS];
            ovf_d[k] = cm ^ gc[GPS];
        end
    end

    // The whole pipe moves or holds as one; bubbles ride along as v_q=0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                s_q[k]   <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                ovf_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= v_d[k];
                s_q[k]   <= s_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                c_q[k]   <= c_d[k];
                ovf_q[k] <= ovf_d[k];
            end
        end
    end

    // Gate with the valid bit so results read 0 whenever nothing is presented,
    // including immediately on reset assertion.
    assign sum  = out_valid ? s_q[LAST] : '0;
    assign cout = out_valid & c_q[LAST];
    assign ovf  = out_valid & ovf_q[LAST];

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - scoreboard bench for cla_pipe_addsub over several widths and depths
`timescale 1ns/1ps

module tb_cla_pipe_addsub;

    localparam int NI = 5;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          cin_in;
    logic          sub_in;
    logic          out_ready;
    logic [63:0]   a_in;
    logic [63:0]   b_in;

    logic [NI-1:0] ir_w;
    logic [NI-1:0] ov_w;
    logic [NI-1:0] co_w;
    logic [NI-1:0] of_w;
    logic [31:0]   s0;
    logic [31:0]   s1;
    logic [31:0]   s2;
    logic [15:0]   s3;
    logic [63:0]   s4;

    exp_t q [NI][$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   pops [NI];
    logic stall_p [NI];
    exp_t saved [NI];
    logic acc0;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(32), .GROUP(4), .STAGES(2)) u0 (
        .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(ir_w[0]),
        .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin_in), .sub(sub_in),
        .out_valid(ov_w[0]), .out_ready(out_ready), .sum(s0), .cout(co_w[0]), .ovf(of_w[0]));

    cla_pipe_addsub #(.WIDTH(32), .GROUP(4), .STAGES(1)) u1 (
        .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(ir_w[1]),
        .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin_in), .sub(sub_in),
        .out_valid(ov_w[1]), .out_ready(out_ready), .sum(s1), .cout(co_w[1]), .ovf(of_w[1]));

    cla_pipe_addsub #(.WIDTH(32), .GROUP(4), .STAGES(4)) u2 (
        .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(ir_w[2]),
        .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin_in), .sub(sub_in),
        .out_valid(ov_w[2]), .out_ready(out_ready), .sum(s2), .cout(co_w[2]), .ovf(of_w[2]));

    cla_pipe_addsub #(.WIDTH(16), .GROUP(4), .STAGES(2)) u3 (
        .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(ir_w[3]),
        .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in), .sub(sub_in),
        .out_valid(ov_w[3]), .out_ready(out_ready), .sum(s3), .cout(co_w[3]), .ovf(of_w[3]));

    cla_pipe_addsub #(.WIDTH(64), .GROUP(4), .STAGES(4)) u4 (
        .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(ir_w[4]),
        .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(ov_w[4]), .out_ready(out_ready), .sum(s4), .cout(co_w[4]), .ovf(of_w[4]));

    function automatic int wid(input int i);
        case (i)
            3:       return 16;
            4:       return 64;
            default: return 32;
        endcase
    endfunction

    function automatic logic [63:0] get_sum(input int i);
        case (i)
            0:       return 64'(s0);
            1:       return 64'(s1);
            2:       return 64'(s2);
            3:       return 64'(s3);
            default: return s4;
        endcase
    endfunction

    // Reference: integer arithmetic; overflow = signed result out of range,
    // subtract carry = no borrow (a >= b unsigned).
    function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic c, input logic s);
        logic [127:0]        m;
        logic [127:0]        ua;
        logic [127:0]        ub;
        logic [127:0]        u;
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        logic signed [127:0] sc;
        logic signed [127:0] sr;
        logic signed [127:0] smax;
        logic signed [127:0] smin;
        exp_t                e;
        m  = (128'd1 << w) - 128'd1;
        ua = 128'(av) & m;
        ub = 128'(bv) & m;
        sa = $signed(ua << (128 - w)) >>> (128 - w);
        sb = $signed(ub << (128 - w)) >>> (128 - w);
        sc = $signed(128'(c));
        if (s) begin
            u      = ua - ub;
            e.cout = (ua >= ub);
            sr     = sa - sb;
        end else begin
            u      = ua + ub + 128'(c);
            e.cout = u[w];
            sr     = sa + sb + sc;
        end
        smax  = 128'sd1;
        smax  = (smax <<< (w - 1)) - 128'sd1;
        smin  = -smax - 128'sd1;
        e.ovf = (sr > smax) || (sr < smin);
        e.sum = 64'(u & m);
        return e;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h", nm, inst, act, exp);
        end
    endtask

    // Inputs change on the falling edge; expected results are queued for every
    // instance that accepts the operands at the coming rising edge.
    task automatic drive_cycle(input logic v, input logic [63:0] av, input logic [63:0] bv,
                               input logic c, input logic s, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        a_in      = av;
        b_in      = bv;
        cin_in    = c;
        sub_in    = s;
        out_ready = rdy;
        #1;
        acc0 = v && ir_w[0] && rst_n;
        if (rst_n && v) begin
            for (int i = 0; i < NI; i++)
                if (ir_w[i]) q[i].push_back(model(wid(i), av, bv, c, s));
        end
    endtask

    task automatic directed(input string nm, input logic [63:0] av, input logic [63:0] bv,
                            input logic c, input logic s,
                            input logic [31:0] es, input logic ec, input logic eo);
        drive_cycle(1'b1, av, bv, c, s, 1'b1);
        chk({nm, "_accept"}, 0, acc0, 1);
        drive_cycle(1'b0, av, bv, c, s, 1'b1);
        chk({nm, "_latency_early"}, 0, ov_w[0], 0);
        drive_cycle(1'b0, av, bv, c, s, 1'b1);
        chk({nm, "_valid"}, 0, ov_w[0], 1);
        chk({nm, "_result"}, 0, {s0, co_w[0], of_w[0]}, {es, ec, eo});
    endtask

    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        #2;
        for (int i = 0; i < NI; i++) begin
            cur.sum  = get_sum(i);
            cur.cout = co_w[i];
            cur.ovf  = of_w[i];
            if (!rst_n) begin
                stall_p[i] = 1'b0;
            end else begin
                if (stall_p[i])
                    chk("stall_hold", i, {ov_w[i], cur}, {1'b1, saved[i]});
                if (ov_w[i]) begin
                    if (!out_ready) begin
                        chk("stall_in_ready", i, ir_w[i], 0);
                    end else begin
                        chk("result_expected", i, q[i].size() != 0, 1);
                        if (q[i].size() != 0) begin
                            e = q[i].pop_front();
                            pops[i]++;
                            chk("result", i, cur, e);
                        end
                    end
                end else begin
                    chk("idle_zero", i, cur, 0);
                end
                stall_p[i] = ov_w[i] & ~out_ready;
                saved[i]   = cur;
            end
        end
    end

    initial begin
        logic [63:0] sa [4];
        logic [63:0] sb [4];
        logic [63:0] av;
        logic [63:0] bv;
        int          idx;
        int          p0;
        logic        rdy;

        for (int i = 0; i < NI; i++) begin
            pops[i]    = 0;
            stall_p[i] = 1'b0;
            saved[i]   = '0;
        end
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin_in    = 1'b0;
        sub_in    = 1'b0;
        out_ready = 1'b1;
        acc0      = 1'b0;

        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NI; i++) begin
            chk("reset_out_valid", i, ov_w[i], 0);
            chk("reset_in_ready", i, ir_w[i], 1);
            chk("reset_outputs", i, {get_sum(i), co_w[i], of_w[i]}, 0);
        end
        rst_n = 1'b1;

        directed("carry_wrap", 64'h00FF00FF, 64'hFF00FF01, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        directed("neg_ovf", 64'h80808080, 64'h80808080, 1'b0, 1'b0, 32'h01010100, 1'b1, 1'b1);
        directed("pos_ovf", 64'h7FFFFFFF, 64'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        directed("sub_borrow", 64'h00000000, 64'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        directed("add_cin", 64'h11111111, 64'h22222222, 1'b1, 1'b0, 32'h33333334, 1'b0, 1'b0);

        // Back-to-back stream of 4 with a 3-cycle output stall.
        repeat (4) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            sa[i] = {$urandom(), $urandom()};
            sb[i] = {$urandom(), $urandom()};
        end
        p0  = pops[0];
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            rdy = !(c >= 2 && c < 5);
            drive_cycle(idx < 4, sa[idx < 4 ? idx : 0], sb[idx < 4 ? idx : 0], c[0], c[1], rdy);
            if (acc0) idx++;
            if (!rdy && ov_w[0]) chk("stream_stall_ready", 0, ir_w[0], 0);
        end
        chk("stream_accepted", 0, idx, 4);
        chk("stream_retired", 0, pops[0] - p0, 4);

        // Asynchronous reset with two results in flight.
        drive_cycle(1'b1, 64'h0000000000000005, 64'h0000000000000007, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 64'h0000000000000009, 64'h0000000000000003, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_pre_valid", 0, ov_w[0], 1);
        rst_n = 1'b0;
        #0.5;
        chk("rst_async_valid", 0, ov_w[0], 0);
        chk("rst_async_outputs", 0, {s0, co_w[0], of_w[0]}, 0);
        chk("rst_in_ready", 0, ir_w[0], 1);
        for (int i = 0; i < NI; i++) q[i].delete();
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_hold_valid", 0, ov_w[0], 0);
        rst_n = 1'b1;
        directed("post_reset", 64'h11111111, 64'h22222222, 1'b1, 1'b0, 32'h33333334, 1'b0, 1'b0);

        // Random traffic with random bubbles and back-pressure.
        for (int n = 0; n < 3000; n++) begin
            av = {$urandom(), $urandom()};
            bv = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: av = '1;
                1: bv = 64'h8000800080008000;
                2: av = 64'h7FFF7FFF7FFF7FFF;
                3: bv = '0;
                default: ;
            endcase
            drive_cycle($urandom_range(0, 9) < 7, av, bv, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end

        repeat (12) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NI; i++) chk("drain_empty", i, q[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_pipe_addsub.md
CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a multiple of GROUP.
REQ-002 Parameter GROUP, default 4, carry-lookahead group size in bits.
REQ-003 Parameter STAGES, default 2, pipeline depth; legal range 1..WIDTH/GROUP, and (WIDTH/GROUP) SHALL be divisible by STAGES.
REQ-004 clock  input  1  single rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 in_valid  input  1  operand set present on a, b, cin, sub.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in; used only when sub=0.
REQ-011 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-012 out_valid  output  1  sum, cout, ovf hold a valid result.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of bit WIDTH-1.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 add: result = a + b + cin; sub: result = a + ~b + 1, cin ignored; all arithmetic modulo 2^WIDTH.
REQ-018 cout = carry out of MSB (in sub mode, cout=1 means no borrow).
REQ-019 ovf = carry into MSB XOR carry out of MSB.
REQ-020 Carries within each GROUP-bit group SHALL use generate/propagate lookahead; group carries SHALL use group-level lookahead within a stage.
REQ-021 Stage k (0..STAGES-1) computes groups k*(WIDTH/GROUP/STAGES) through (k+1)*(WIDTH/GROUP/STAGES)-1; inter-stage carry and unprocessed operand bits SHALL be registered alongside partial sums.
REQ-022 Each stage has a valid bit; pipeline advance = out_ready OR NOT out_valid; when advance=0 all stage registers hold.
REQ-023 in_ready = advance (combinational); a transfer occurs on a rising edge where in_valid AND in_ready.
REQ-024 Latency: result of a transfer at edge N SHALL appear with out_valid=1 after edge N+STAGES-1 when no stall occurs; throughput one result per cycle.
REQ-025 Stall: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid SHALL remain stable and in_ready=0.
REQ-026 Bubbles (in_valid=0 at an advancing edge) SHALL propagate as invalid stages; results SHALL never be duplicated, dropped or reordered.
REQ-027 Simultaneous out_ready=1 and in_valid=1 with full pipeline: output retires and new operand enters on the same edge.
REQ-028 Data registers of invalid stages are don't-care internally, but sum/cout/ovf SHALL read 0 whenever out_valid=0.

Reset
REQ-029 reset=0 SHALL immediately clear all stage valid bits, out_valid, sum, cout, ovf to 0, independent of clock.
REQ-030 Reset mid-operation discards all in-flight results; first valid output after release corresponds to the first transfer after release.
REQ-031 in_ready SHALL be 1 during and after reset (pipeline empty).

Verification (WIDTH=32, GROUP=4, STAGES=2, out_ready=1 unless stated)
REQ-032 a=00FF_00FF, b=FF00_FF01, cin=0, sub=0 -> sum=0000_0000, cout=1, ovf=0, out_valid one edge after the transfer edge.
REQ-033 a=8080_8080, b=8080_8080, add -> sum=0101_0100, cout=1, ovf=1; a=7FFF_FFFF, b=0000_0001 -> sum=8000_0000, cout=0, ovf=1.
REQ-034 sub=1, a=0000_0000, b=0000_0001, cin=1 -> sum=FFFF_FFFF, cout=0, ovf=0 (cin ignored); a=1111_1111, b=2222_2222, add, cin=1 -> sum=3333_3334.
REQ-035 Stream 4 back-to-back operand sets, drop out_ready for 3 cycles mid-stream -> in_ready=0 while stalled, outputs stable, all 4 results in order, none lost or duplicated.
REQ-036 Assert reset=0 between clock edges with 2 results in flight -> out_valid/sum/cout/ovf go 0 without a clock edge; after release only post-reset transfers emerge.
REQ-037 Randomised add/sub with random in_valid/out_ready against a reference model at STAGES=1, 2, 4 and WIDTH=16, 64 -> zero mismatches.
